moore_seq_gen: RTL and testbench
================================

// Module: moore_seq_gen
// PURPOSE
//   Serial bit-stream generator; the transmit-side counterpart of the moore
//   sequence detector. Loads a WIDTH-bit pattern and shifts it out MSB-first,
//   one bit per clk, repeated repeat_cnt+1 times with no gap between passes.
//   Drives the detector's serial 'in' input in system and bench use.
// PARAMETERS
//   WIDTH  8  pattern length in bits (>=2)
//   CNT_W  4  width of repeat_cnt; maximum 2**CNT_W passes
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous, active-high reset
//   start       in   1      request transmission; sampled only in IDLE
//   pattern     in   WIDTH  pattern to send, captured when start is accepted
//   repeat_cnt  in   CNT_W  extra passes; passes sent = repeat_cnt+1
//   out         out  1      serial data bit (registered)
//   out_valid   out  1      1 while out carries a pattern/parity bit
//   busy        out  1      1 from the accept edge until return to IDLE
//   done        out  1      one-cycle pulse after the last bit
// BEHAVIOUR
//   - All outputs registered. rst=1 at a rising edge: state=IDLE,
//     out=0, out_valid=0, busy=0, done=0, shift reg/counters cleared.
//   - rst overrides everything, including mid-pass; the partial pass is lost
//     and no done pulse is issued.
//   - FSM states: IDLE, SHIFT, PAR (PARITY_EN only), DONE.
//   - IDLE: start=1 at edge k -> capture pattern and repeat_cnt, go to SHIFT.
//     After edge k: out=pattern[WIDTH-1], out_valid=1, busy=1 (latency 1).
//   - SHIFT: each edge shifts left; bit i of a pass is visible for exactly one
//     cycle. A bit counter (log2 WIDTH bits) marks the last bit (pattern[0]).
//   - End of pass: if passes remain, reload the captured pattern, decrement the
//     pass counter and present the new pass's MSB on the next cycle, with no
//     bubble. Otherwise go to DONE.
//   - DONE: out=0, out_valid=0, done=1, busy=1 for exactly one cycle, then
//     IDLE with busy=0.
//   - start is ignored in SHIFT, PAR and DONE; it is not queued.
//     pattern/repeat_cnt changes after the accept edge have no effect.
//   - repeat_cnt = 2**CNT_W-1 gives 2**CNT_W passes. The counter never wraps;
//     it stops at 0.
//   - Total active cycles per job: (repeat_cnt+1)*WIDTH (+1 per pass with
//     PARITY_EN), then 1 DONE cycle.
// CONFIGURATION
//   PARITY_EN defined: after each pass's last bit, state PAR drives one extra
//     bit, out = ^pattern (even parity over the captured pattern), out_valid=1.
//     It then reloads or goes to DONE as above.
//   PARITY_EN undefined: state PAR and the parity logic are not compiled.
//     Passes run back-to-back.
// TESTING
//   1 rst=1 two edges then 0 -> out=0, out_valid=0, busy=0, done=0.
//   2 pattern=8'b1001_0110, repeat_cnt=0, start 1 cycle -> next 8 cycles
//     out=1,0,0,1,0,1,1,0 with out_valid=1, then done=1 for 1 cycle, busy=0
//     after.
//   3 pattern=8'b1100_0001, repeat_cnt=2 -> 24 contiguous valid bits (pattern
//     x3, no gap), then a single done pulse.
//   4 start held high during SHIFT, pattern changed to 8'hFF mid-job -> stream
//     unchanged, exactly one done. A new job starts only from IDLE.
//   5 rst=1 at bit 4 of a pass -> next cycle all outputs 0, no done pulse.
//     A following start sends a full fresh pass.
//   6 PARITY_EN, pattern=8'b1011_0000, repeat_cnt=1 -> 18 valid bits, bits 9
//     and 18 = 1. Undefined: 16 bits. Also loop out into the moore detector
//     and check its out.

Source files
------------

// File: rtl/moore_seq_gen.sv
// moore_seq_gen: serial bit-stream generator. It loads a WIDTH-bit pattern and
// shifts it out MSB-first, one bit per clock. The pattern is sent
// repeat_cnt+1 times back-to-back, and then a one-cycle done pulse follows.
// This block drives the serial input of the moore sequence detector.
//
// Optional feature: define PARITY_EN to append one even-parity bit (^pattern)
// after every pass.
//
// Parameters:
//   WIDTH  pattern length in bits (>= 2)
//   CNT_W  width of repeat_cnt; up to 2**CNT_W passes
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset
//   i_start       request a job; sampled only while idle
//   i_pattern     pattern, captured on the accept edge
//   i_repeat_cnt  extra passes (passes sent = i_repeat_cnt + 1)
//   o_out         registered serial data bit
//   o_out_valid   high while o_out carries a pattern or parity bit
//   o_busy        high from the accept edge until the return to idle
//   o_done        one-cycle pulse after the last bit of the job
module moore_seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [CNT_W-1:0] i_repeat_cnt,
  output logic             o_out,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
`ifdef PARITY_EN
    StPar   = 2'd2,
`endif
    StDone  = 2'd3
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_pat, w_pat_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [BitW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic [CNT_W-1:0] r_pass, w_pass_d;
  logic             r_out, w_out_d;
  logic             r_valid, w_valid_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             w_end_pass;

  always_comb begin
    w_state_d   = r_state;
    w_pat_d     = r_pat;
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_pass_d    = r_pass;
    w_out_d     = 1'b0;
    w_valid_d   = 1'b0;
    w_busy_d    = 1'b0;
    w_done_d    = 1'b0;
    w_end_pass  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_pat_d     = i_pattern;
          w_shift_d   = i_pattern;
          w_bit_cnt_d = '0;
          w_pass_d    = i_repeat_cnt;
          w_out_d     = i_pattern[WIDTH-1];
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b1;
          w_state_d   = StShift;
        end
      end
      StShift: begin
        if (r_bit_cnt == LastBit) begin
`ifdef PARITY_EN
          w_state_d = StPar;
          w_out_d   = ^r_pat;
          w_valid_d = 1'b1;
          w_busy_d  = 1'b1;
`else
          w_end_pass = 1'b1;
`endif
        end else begin
          // r_shift[WIDTH-1] is the bit on o_out now; the next one sits below it.
          w_shift_d   = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_d = r_bit_cnt + 1'b1;
          w_out_d     = r_shift[WIDTH-2];
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b1;
        end
      end
`ifdef PARITY_EN
      StPar: w_end_pass = 1'b1;
`endif
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // End of pass: reload without a bubble if passes remain, otherwise finish.
    if (w_end_pass) begin
      w_busy_d = 1'b1;
      if (r_pass != '0) begin
        w_pass_d    = r_pass - 1'b1;
        w_shift_d   = r_pat;
        w_bit_cnt_d = '0;
        w_out_d     = r_pat[WIDTH-1];
        w_valid_d   = 1'b1;
        w_state_d   = StShift;
      end else begin
        w_done_d  = 1'b1;
        w_state_d = StDone;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pat     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_pass    <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pat     <= w_pat_d;
      r_shift   <= w_shift_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_pass    <= w_pass_d;
      r_out     <= w_out_d;
      r_valid   <= w_valid_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen (WIDTH=8, CNT_W=4). Each expected
// cycle {out, out_valid, busy, done} is queued when stimulus is driven and
// compared after the following clock edge.
module tb_moore_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] repeat_cnt = '0;
  logic       out, out_valid, busy, done;

  moore_seq_gen #(.WIDTH(8), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_pattern   (pattern),
    .i_repeat_cnt(repeat_cnt),
    .o_out       (out),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] rc;
    int         exp_bits;  // valid bits without parity
  } job_t;

  logic [3:0] q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_valid = 0;
  int    n_done = 0;
  int    cyc = 0;
  string tag = "reset";

`ifdef PARITY_EN
  localparam int ParBit = 1;
`else
  localparam int ParBit = 0;
`endif

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock edge; compare outputs against the next queued expectation.
  task automatic step();
    logic [3:0] exp;
    logic [3:0] got;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp = q.pop_front();
      got = {out, out_valid, busy, done};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got {out,valid,busy,done}=%b, expected %b",
                 tag, cyc, got, exp);
      end
      if (out_valid) n_valid++;
      if (done) n_done++;
    end
  endtask

  task automatic push_job(input logic [7:0] pat, input logic [3:0] rc);
    for (int p = 0; p <= int'(rc); p++) begin
      for (int b = 7; b >= 0; b--) q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
`ifdef PARITY_EN
      q.push_back({^pat, 1'b1, 1'b1, 1'b0});
`endif
    end
    q.push_back(4'b0011);
    q.push_back(4'b0000);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      step();
      guard++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d pending, expected 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic run_job(input logic [7:0] pat, input logic [3:0] rc);
    push_job(pat, rc);
    pattern    = pat;
    repeat_cnt = rc;
    start      = 1'b1;
    step();
    start = 1'b0;
    drain();
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{pat: 8'b1001_0110, rc: 4'd0,  exp_bits: 8};
    jobs[1] = '{pat: 8'b1100_0001, rc: 4'd2,  exp_bits: 24};
    jobs[2] = '{pat: 8'hA5,        rc: 4'd15, exp_bits: 128};
    jobs[3] = '{pat: 8'h00,        rc: 4'd0,  exp_bits: 8};
    jobs[4] = '{pat: 8'hFF,        rc: 4'd1,  exp_bits: 16};
    jobs[5] = '{pat: 8'b1011_0000, rc: 4'd1,  exp_bits: 16};

    // Reset: two edges with rst high, then idle.
    rst = 1'b1;
    q.push_back(4'b0000);
    q.push_back(4'b0000);
    step();
    step();
    rst = 1'b0;
    q.push_back(4'b0000);
    step();

    // Table-driven jobs.
    for (int j = 0; j < 6; j++) begin
      tag     = $sformatf("job%0d", j);
      n_valid = 0;
      n_done  = 0;
      run_job(jobs[j].pat, jobs[j].rc);
      check_int({tag, "_bits"}, n_valid, jobs[j].exp_bits + ParBit * (int'(jobs[j].rc) + 1));
      check_int({tag, "_done"}, n_done, 1);
    end

    // start held high through the job, pattern changed mid-job.
    tag     = "hold_start";
    n_valid = 0;
    n_done  = 0;
    push_job(8'b0110_1001, 4'd1);
    pattern    = 8'b0110_1001;
    repeat_cnt = 4'd1;
    start      = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      if (i == 3) begin
        pattern    = 8'hFF;
        repeat_cnt = 4'd5;
      end
      if (q.size() == 1) start = 1'b0;  // drop start before idle would re-accept
      step();
    end
    check_int("hold_start_pending", q.size(), 0);
    check_int("hold_start_done", n_done, 1);
    check_int("hold_start_bits", n_valid, 16 + 2 * ParBit);
    q.push_back(4'b0000);
    step();

    // Reset while bit 4 of a pass is on the output.
    tag = "mid_reset";
    push_job(8'h5A, 4'd0);
    pattern    = 8'h5A;
    repeat_cnt = 4'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    q.delete();
    q.push_back(4'b0000);
    step();
    rst    = 1'b0;
    n_done = 0;
    q.push_back(4'b0000);
    q.push_back(4'b0000);
    step();
    step();
    check_int("mid_reset_no_done", n_done, 0);

    tag     = "after_reset";
    n_valid = 0;
    n_done  = 0;
    run_job(8'h3C, 4'd0);
    check_int("after_reset_bits", n_valid, 8 + ParBit);
    check_int("after_reset_done", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
